uart_tx: RTL and testbench

Serial UART transmitter, 8N1 by default, LSB first, idle-high line. Pairs with the existing UART receiver on the same clk50M domain and the same baud constants. Bytes arrive from the XINTF-side logic over a valid/ready handshake and are shifted out on rs232_tx. A done pulse marks the end of each frame.

---
 rtl/uart_pkg.sv | 32 +++
 rtl/uart_baud_tick.sv | 28 ++
 rtl/uart_tx.sv | 113 +++++++++++
 tb/tb_uart_tx.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART constants: baud divider end values, frame width and tx state encoding.
package uart_pkg;

   // Cycles per bit minus one, rounded to the nearest whole divider.
   localparam int BAUD_END_9600_50M    = 5207;
   localparam int BAUD_END_115200_50M  = 433;
   localparam int BAUD_END_460800_50M  = 107;
   localparam int BAUD_END_9600_200M   = 20832;
   localparam int BAUD_END_115200_200M = 1735;
   localparam int BAUD_END_460800_200M = 433;

   localparam int DATA_BITS = 8;

   localparam logic [2:0] ST_IDLE   = 3'd0;
   localparam logic [2:0] ST_START  = 3'd1;
   localparam logic [2:0] ST_DATA   = 3'd2;
   localparam logic [2:0] ST_PARITY = 3'd3;
   localparam logic [2:0] ST_STOP   = 3'd4;

   typedef enum logic [2:0] {
      IDLE   = ST_IDLE,
      START  = ST_START,
      DATA   = ST_DATA,
      PARITY = ST_PARITY,
      STOP   = ST_STOP
   } tx_state_t;

   function automatic logic frame_parity(input logic [DATA_BITS-1:0] data, input logic odd);
      return (^data) ^ odd;
   endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Bit-period timer: counts 0..BAUD_END while enabled, pulses tick on the last count.
module uart_baud_tick #(
   parameter int BAUD_END = 107
) (
   input  logic clk50M,
   input  logic rst_n,
   input  logic en,
   output logic tick
);

   localparam int CW = $clog2(BAUD_END + 1);

   logic [CW-1:0] cnt;

   // NOTE: clocked state is written with non-blocking assignments only.
   always_ff @(posedge clk50M) begin
      if (!rst_n || !en) begin
         cnt <= '0;
      end else if (cnt == CW'(BAUD_END)) begin
         cnt <= '0;
      end else begin
         cnt <= cnt + CW'(1);
      end
   end

   assign tick = en && (cnt == CW'(BAUD_END));

endmodule

// File: rtl/uart_tx.sv
// UART transmitter, 8N1 LSB first, idle-high registered line.
// Define UART_TX_PARITY_EN to insert a parity bit after the data bits.
module uart_tx
   import uart_pkg::*;
#(
   parameter int BAUD_END  = BAUD_END_460800_50M,
   parameter int STOP_BITS = 1
`ifdef UART_TX_PARITY_EN
   ,
   parameter bit PARITY_ODD = 1'b0
`endif
) (
   input  logic       clk50M,
   input  logic       rst_n,
   input  logic [7:0] tx_data,
   input  logic       tx_valid,
   output logic       tx_ready,
   output logic       rs232_tx,
   output logic       tx_busy,
   output logic       flag_end
);

   localparam logic [2:0] LAST_DATA = 3'(DATA_BITS - 1);
   localparam logic [2:0] LAST_STOP = 3'(STOP_BITS - 1);

   tx_state_t  state, state_next;
   logic       tick, handshake;
   logic       line_next, end_next;
   logic [7:0] shift;
   logic [2:0] bit_cnt;
`ifdef UART_TX_PARITY_EN
   logic       parity_bit;
`endif

   assign tx_ready  = rst_n && (state == IDLE);
   assign tx_busy   = (state != IDLE);
   assign handshake = tx_valid && tx_ready;

   uart_baud_tick #(.BAUD_END(BAUD_END)) u_baud (
      .clk50M (clk50M),
      .rst_n  (rst_n),
      .en     (tx_busy),
      .tick   (tick)
   );

   always_ff @(posedge clk50M) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_next;
   end

   // NOTE: every output of this block is defaulted first so no latch can form.
   always_comb begin
      state_next = state;
      line_next  = 1'b1;
      end_next   = 1'b0;
      case (state)
         IDLE:  if (handshake) state_next = START;
         START: begin
            line_next = 1'b0;
            if (tick) state_next = DATA;
         end
         DATA: begin
            line_next = shift[0];
`ifdef UART_TX_PARITY_EN
            if (tick && bit_cnt == LAST_DATA) state_next = PARITY;
`else
            if (tick && bit_cnt == LAST_DATA) state_next = STOP;
`endif
         end
`ifdef UART_TX_PARITY_EN
         PARITY: begin
            line_next = parity_bit;
            if (tick) state_next = STOP;
         end
`endif
         STOP: begin
            if (tick && bit_cnt == LAST_STOP) begin
               state_next = IDLE;
               end_next   = 1'b1;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   // The line is registered from the current state, so it trails state by one cycle.
   always_ff @(posedge clk50M) begin
      if (!rst_n) begin
         shift    <= '0;
         bit_cnt  <= '0;
         rs232_tx <= 1'b1;
         flag_end <= 1'b0;
      end else begin
         rs232_tx <= line_next;
         flag_end <= end_next;
         if (handshake) begin
            shift   <= tx_data;
            bit_cnt <= '0;
         end else if (tick) begin
            if (state == DATA) shift <= shift >> 1;
            bit_cnt <= (state_next == state) ? bit_cnt + 3'd1 : 3'd0;
         end
      end
   end

`ifdef UART_TX_PARITY_EN
   always_ff @(posedge clk50M) begin
      if (!rst_n)         parity_bit <= 1'b0;
      else if (handshake) parity_bit <= frame_parity(tx_data, PARITY_ODD);
   end
`endif

endmodule

// File: tb/tb_uart_tx.sv
// Self-checking bench for uart_tx: logs the line every cycle and compares it with a frame-level model.
module tb_uart_tx;

   localparam int BIT_CYC = 108;
   localparam int HALF    = 54;
`ifdef UART_TX_PARITY_EN
   localparam int NBITS   = 11;
`else
   localparam int NBITS   = 10;
`endif
   localparam int FRAME_CYC = NBITS * BIT_CYC;
   localparam int NO_ABORT  = 32'h7fff_ffff;

   logic       clk50M   = 1'b0;
   logic       rst_n    = 1'b0;
   logic       tx_valid = 1'b0;
   logic [7:0] tx_data  = 8'h00;
   logic       tx_ready, rs232_tx, tx_busy, flag_end;

   int n_checks = 0;
   int n_fail   = 0;

   uart_tx #(.BAUD_END(107), .STOP_BITS(1)) dut (
      .clk50M   (clk50M),
      .rst_n    (rst_n),
      .tx_data  (tx_data),
      .tx_valid (tx_valid),
      .tx_ready (tx_ready),
      .rs232_tx (rs232_tx),
      .tx_busy  (tx_busy),
      .flag_end (flag_end)
   );

   always #10 clk50M = ~clk50M;

   initial begin
      #(20 * 100000);
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   // Index i of each log holds the values seen just after posedge number i.
   logic line_log[$], ready_log[$], busy_log[$], flag_log[$], rst_log[$];
   always @(negedge clk50M) begin
      line_log.push_back(rs232_tx);
      ready_log.push_back(tx_ready);
      busy_log.push_back(tx_busy);
      flag_log.push_back(flag_end);
      rst_log.push_back(rst_n);
   end

   // Reference model: which edges accept a byte, and which edges reset.
   int         cyc     = 0;
   int         free_at = 0;
   int         hs_cyc[$];
   logic [7:0] hs_data[$];
   int         rst_edges[$];
   always @(posedge clk50M) begin
      if (!rst_n) begin
         rst_edges.push_back(cyc);
         free_at = cyc + 1;
      end else if (tx_valid && cyc >= free_at) begin
         hs_cyc.push_back(cyc);
         hs_data.push_back(tx_data);
         free_at = cyc + FRAME_CYC + 1;
      end
      cyc++;
   end

   function automatic logic frame_bit(input logic [7:0] d, input int j);
      if (j == 0) return 1'b0;
      if (j <= 8) return d[j-1];
`ifdef UART_TX_PARITY_EN
      if (j == 9) return ^d;
`endif
      return 1'b1;
   endfunction

   function automatic int abort_of(input int n);
      foreach (rst_edges[k]) if (rst_edges[k] > n) return rst_edges[k];
      return NO_ABORT;
   endfunction

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic compare_model(input string tag, input int from, input int to);
      int   el = 0, er = 0, eb = 0, ef = 0;
      int   ab[$];
      logic xl, xb, xf;
      foreach (hs_cyc[k]) ab.push_back(abort_of(hs_cyc[k]));
      for (int i = from; i < to; i++) begin
         xl = 1'b1; xb = 1'b0; xf = 1'b0;
         for (int k = 0; k < hs_cyc.size(); k++) begin
            int n = hs_cyc[k];
            if (i >= n && i < n + FRAME_CYC && i < ab[k]) xb = 1'b1;
            if (i >= n + 1 && i < n + 1 + FRAME_CYC && i < ab[k])
               xl = frame_bit(hs_data[k], (i - n - 1) / BIT_CYC);
            if (i == n + FRAME_CYC && ab[k] > i) xf = 1'b1;
         end
         if (line_log[i] !== xl) el++;
         if (busy_log[i] !== xb) eb++;
         if (flag_log[i] !== xf) ef++;
         if (rst_log[i] === 1'b1 && ready_log[i] !== !xb) er++;
      end
      check({tag, "_line_cycles_wrong"},  el, 0);
      check({tag, "_busy_cycles_wrong"},  eb, 0);
      check({tag, "_flag_cycles_wrong"},  ef, 0);
      check({tag, "_ready_cycles_wrong"}, er, 0);
   endtask

   logic [7:0]  dec_byte[$];
   int          dec_start[$];
   logic [15:0] dec_raw[$];

   // Line-only decoder: find a falling edge, then sample each bit at its middle.
   task automatic decode(input int from, input int to);
      int          i;
      logic [15:0] raw;
      dec_byte.delete(); dec_start.delete(); dec_raw.delete();
      i = (from < 1) ? 1 : from;
      while (i < to) begin
         if (line_log[i-1] === 1'b1 && line_log[i] === 1'b0 &&
             i + (NBITS - 1) * BIT_CYC + HALF < to) begin
            raw = '0;
            for (int j = 0; j < NBITS; j++) raw[j] = line_log[i + j * BIT_CYC + HALF];
            dec_raw.push_back(raw);
            dec_byte.push_back(raw[8:1]);
            dec_start.push_back(i);
            i = i + (NBITS - 1) * BIT_CYC + HALF;
         end
         i++;
      end
   endtask

   task automatic analyze(input string tag, input int from, input int to, input logic [7:0] exp_b[$]);
      decode(from, to);
      check({tag, "_frames"}, dec_byte.size(), exp_b.size());
      for (int k = 0; k < exp_b.size() && k < dec_byte.size(); k++) begin
         check($sformatf("%s_byte%0d", tag, k), dec_byte[k], exp_b[k]);
         check($sformatf("%s_stop%0d", tag, k), dec_raw[k][NBITS-1], 1'b1);
      end
      compare_model(tag, from, to);
   endtask

   task automatic idle(input int n);
      repeat (n) begin @(negedge clk50M); #1; end
   endtask

   // Called just after a negedge; returns the edge index that accepted the byte.
   task automatic send(input logic [7:0] d, input bit keep, output int hs);
      int budget = 0;
      tx_data  = d;
      tx_valid = 1'b1;
      while (tx_ready !== 1'b1 && budget < 3 * FRAME_CYC) begin
         @(negedge clk50M); #1;
         budget++;
      end
      if (tx_ready !== 1'b1) begin
         check("accept_timeout", 0, 1);
         tx_valid = 1'b0;
         hs = -1;
         return;
      end
      @(posedge clk50M);
      @(negedge clk50M); #1;
      hs = line_log.size() - 1;
      if (!keep) tx_valid = 1'b0;
   endtask

   initial begin
      int         mark, hs, hs2, nf, fi, nr, gap;
      logic [7:0] d;
      logic [7:0] exp_q[$];

      idle(4);
      check("rst_line", rs232_tx, 1'b1);
      check("rst_busy", tx_busy, 1'b0);
      check("rst_flag", flag_end, 1'b0);
      rst_n = 1'b1;
      idle(1);
      check("rst_ready", tx_ready, 1'b1);

      // Single 0x55 frame.
      mark = line_log.size();
      send(8'h55, 1'b0, hs);
      idle(FRAME_CYC + 20);
      exp_q = '{8'h55};
      analyze("b55", mark, line_log.size(), exp_q);
      if (dec_raw.size() > 0) check("b55_midbits", dec_raw[0][8:0], 9'h0AA);
      nf = 0; fi = -1; nr = 0;
      for (int i = mark; i < line_log.size(); i++) if (flag_log[i]) begin nf++; fi = i; end
      for (int i = hs; i < hs + FRAME_CYC; i++) if (ready_log[i]) nr++;
      check("b55_flag_count", nf, 1);
      check("b55_flag_offset", fi - hs, FRAME_CYC);
      check("b55_ready_high_in_frame", nr, 0);

      // Back-to-back with tx_valid held high.
      mark = line_log.size();
      send(8'hA5, 1'b1, hs);
      send(8'h3C, 1'b0, hs2);
      idle(FRAME_CYC + 20);
      exp_q = '{8'hA5, 8'h3C};
      analyze("b2b", mark, line_log.size(), exp_q);
      check("b2b_period", hs2 - hs, FRAME_CYC + 1);
      if (dec_start.size() == 2) check("b2b_idle_gap", dec_start[1] - dec_start[0] - FRAME_CYC, 1);

      // tx_data changes mid-frame without a handshake.
      mark = line_log.size();
      send(8'h0F, 1'b0, hs);
      idle(300);
      tx_data = 8'hFF;
      idle(FRAME_CYC);
      exp_q = '{8'h0F};
      analyze("chg", mark, line_log.size(), exp_q);

      // Reset during data bit 3 of 0x00.
      mark = line_log.size();
      send(8'h00, 1'b0, hs);
      idle(hs + 1 + 4 * BIT_CYC + HALF - (line_log.size() - 1));
      rst_n = 1'b0;
      idle(1);
      check("abort_line", rs232_tx, 1'b1);
      check("abort_busy", tx_busy, 1'b0);
      check("abort_flag", flag_end, 1'b0);
      idle(2);
      rst_n = 1'b1;
      idle(1);
      check("abort_ready", tx_ready, 1'b1);
      idle(FRAME_CYC + 20);
      nf = 0;
      for (int i = mark; i < line_log.size(); i++) if (flag_log[i]) nf++;
      check("abort_flag_count", nf, 0);
      compare_model("abort", mark, line_log.size());
      mark = line_log.size();
      send(8'h81, 1'b0, hs);
      idle(FRAME_CYC + 20);
      exp_q = '{8'h81};
      analyze("post_abort", mark, line_log.size(), exp_q);

      // Random bytes, mixing held-valid streaming with long idle gaps.
      mark = line_log.size();
      exp_q.delete();
      for (int k = 0; k < 24; k++) begin
         d   = 8'($urandom);
         gap = ($urandom_range(0, 1) == 0) ? 0 : $urandom_range(1000, 1200);
         send(d, (gap == 0) && (k < 23), hs);
         exp_q.push_back(d);
         if (gap > 0) idle(gap);
      end
      tx_valid = 1'b0;
      idle(FRAME_CYC + 20);
      analyze("rand", mark, line_log.size(), exp_q);

      compare_model("whole_run", 0, line_log.size());

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
